// File: rtl/mux_bus16b_sel1b_arb_pkg.sv
// Shared definitions for the 16-bit bus return-path mux and its demux counterpart.
package mux_bus16b_sel1b_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        FULL = 1'b1
    } state_t;

    // Bus owner encoding, shared with the demux that consumes SEL_BUS.
    localparam logic SEL_R0 = 1'b0;
    localparam logic SEL_R1 = 1'b1;

    localparam int unsigned BUS_W_DEFAULT = 16;

endpackage

// File: rtl/mux_bus16b_sel1b_arb_arb_rr2.sv
// Combinational 2-way arbiter: round-robin on ties, or fixed R0 priority
// when MUX_FIXED_PRIO_EN is defined.
module arb_rr2
    import mux_bus16b_sel1b_arb_pkg::*;
(
    input  logic [1:0] eligible,
    input  logic       last_sel,
    output logic       grant_valid,
    output logic       grant_sel
);

    always_comb begin
        grant_valid = |eligible;
        grant_sel   = SEL_R0;
        if (eligible == 2'b11) begin
`ifdef MUX_FIXED_PRIO_EN
            grant_sel = SEL_R0;
`else
            grant_sel = (last_sel == SEL_R0) ? SEL_R1 : SEL_R0;
`endif
        end else if (eligible[1]) begin
            grant_sel = SEL_R1;
        end
    end

endmodule

// File: rtl/mux_bus16b_sel1b_arb.sv
// Two-source return-path mux onto the shared bus with a registered valid/ready
// output stage. Define MUX_FIXED_PRIO_EN for fixed R0 priority on ties.
module mux_bus16b_sel1b_arb
    import mux_bus16b_sel1b_arb_pkg::*;
#(
    parameter int unsigned WIDTH = BUS_W_DEFAULT
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [WIDTH-1:0] R0,
    input  logic             R0_REQ,
    output logic             R0_ACK,
    input  logic [WIDTH-1:0] R1,
    input  logic             R1_REQ,
    output logic             R1_ACK,
    output logic [WIDTH-1:0] TO_BUS,
    output logic             SEL_BUS,
    output logic             BUS_VALID,
    input  logic             BUS_READY
);

    state_t     state;
    logic       last_sel;
    logic [1:0] eligible;
    logic       grant_valid;
    logic       grant_sel;
    logic       can_load;
    logic       capture;

    // A source acknowledged this cycle still shows its old REQ, so mask it.
    assign eligible = {R1_REQ & ~R1_ACK, R0_REQ & ~R0_ACK};
    assign can_load = (state == IDLE) || BUS_READY;
    assign capture  = can_load && grant_valid;

    arb_rr2 u_arb (
        .eligible    (eligible),
        .last_sel    (last_sel),
        .grant_valid (grant_valid),
        .grant_sel   (grant_sel)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= IDLE;
            last_sel <= SEL_R1;
            TO_BUS   <= '0;
            SEL_BUS  <= SEL_R0;
            R0_ACK   <= 1'b0;
            R1_ACK   <= 1'b0;
        end else begin
            R0_ACK <= 1'b0;
            R1_ACK <= 1'b0;
            if (capture) begin
                TO_BUS   <= (grant_sel == SEL_R1) ? R1 : R0;
                SEL_BUS  <= grant_sel;
                last_sel <= grant_sel;
                state    <= FULL;
                R0_ACK   <= (grant_sel == SEL_R0);
                R1_ACK   <= (grant_sel == SEL_R1);
            end else if (state == FULL && BUS_READY) begin
                state <= IDLE;
            end
        end
    end

    assign BUS_VALID = (state == FULL);

endmodule

// File: tb/tb_mux_bus16b_sel1b_arb.sv
// Scoreboard bench for mux_bus16b_sel1b_arb: directed scenarios plus random traffic.
module tb_mux_bus16b_sel1b_arb;

    logic        CLK;
    logic        RST_N;
    logic [15:0] R0, R1;
    logic        R0_REQ, R1_REQ;
    logic        R0_ACK, R1_ACK;
    logic [15:0] TO_BUS;
    logic        SEL_BUS;
    logic        BUS_VALID;
    logic        BUS_READY;

    mux_bus16b_sel1b_arb #(.WIDTH(16)) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .R0        (R0),
        .R0_REQ    (R0_REQ),
        .R0_ACK    (R0_ACK),
        .R1        (R1),
        .R1_REQ    (R1_REQ),
        .R1_ACK    (R1_ACK),
        .TO_BUS    (TO_BUS),
        .SEL_BUS   (SEL_BUS),
        .BUS_VALID (BUS_VALID),
        .BUS_READY (BUS_READY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [15:0] d;
        logic        s;
    } word_t;
    word_t exp_q[$];

    // Reference state: what the bus holds and which source was granted.
    logic        m_valid, m_last, m_ack0, m_ack1, m_sel;
    logic [15:0] m_data;
    logic        mon_en = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_last  = 1'b1;
        m_ack0  = 1'b0;
        m_ack1  = 1'b0;
        m_sel   = 1'b0;
        m_data  = '0;
        exp_q.delete();
    endtask

    // Applies the arbitration rules to the inputs presented for this edge.
    task automatic model_step();
        bit e0, e1, w, n0, n1;
        e0 = R0_REQ && !m_ack0;
        e1 = R1_REQ && !m_ack1;
        n0 = 1'b0;
        n1 = 1'b0;
        if ((!m_valid || BUS_READY) && (e0 || e1)) begin
            if (e0 && e1) begin
`ifdef MUX_FIXED_PRIO_EN
                w = 1'b0;
`else
                w = !m_last;
`endif
            end else begin
                w = e1;
            end
            m_data  = w ? R1 : R0;
            m_sel   = w;
            m_last  = w;
            m_valid = 1'b1;
            exp_q.push_back('{d: m_data, s: w});
            if (w) n1 = 1'b1; else n0 = 1'b1;
        end else if (m_valid && BUS_READY) begin
            m_valid = 1'b0;
        end
        m_ack0 = n0;
        m_ack1 = n1;
    endtask

    task automatic cyc();
        @(posedge CLK);
        model_step();
        #1;
    endtask

    // Monitor: compares the presented bus against the reference; pops a word when it is accepted.
    initial begin
        word_t w;
        forever begin
            @(negedge CLK);
            if (mon_en && RST_N) begin
                check("bus_valid", 32'(BUS_VALID), 32'(m_valid));
                check("r0_ack", 32'(R0_ACK), 32'(m_ack0));
                check("r1_ack", 32'(R1_ACK), 32'(m_ack1));
                check("to_bus_hold", 32'(TO_BUS), 32'(m_data));
                check("sel_bus_hold", 32'(SEL_BUS), 32'(m_sel));
                if (BUS_VALID && BUS_READY) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL accept_unexpected: got %h sel %0d expected no word", TO_BUS, SEL_BUS);
                    end else begin
                        w = exp_q.pop_front();
                        if (TO_BUS !== w.d || SEL_BUS !== w.s) begin
                            errors++;
                            $display("FAIL accept_word: got %h sel %0d expected %h sel %0d",
                                     TO_BUS, SEL_BUS, w.d, w.s);
                        end
                    end
                end
            end
        end
    end

    initial begin
        RST_N = 1'b1;
        R0 = '0; R1 = '0; R0_REQ = 1'b0; R1_REQ = 1'b0; BUS_READY = 1'b0;
        model_reset();
        #1 RST_N = 1'b0;
        #2;
        check("rst_to_bus", 32'(TO_BUS), 32'h0);
        check("rst_sel", 32'(SEL_BUS), 32'h0);
        check("rst_valid", 32'(BUS_VALID), 32'h0);
        check("rst_acks", 32'({R1_ACK, R0_ACK}), 32'h0);
        @(negedge CLK);
        #2 RST_N = 1'b1;
        mon_en = 1'b1;

        // Tie from reset: R0 wins first, then alternation via the ACK mask.
        R0 = 16'hAAAA; R1 = 16'h5555; R0_REQ = 1'b1; R1_REQ = 1'b1; BUS_READY = 1'b1;
        cyc(); check("tie_w0", 32'({SEL_BUS, TO_BUS}), 32'h0_AAAA);
        cyc(); check("tie_w1", 32'({SEL_BUS, TO_BUS}), 32'h1_5555);
        cyc(); check("tie_w2", 32'({SEL_BUS, TO_BUS}), 32'h0_AAAA);
        cyc(); check("tie_w3", 32'({SEL_BUS, TO_BUS}), 32'h1_5555);
        R0_REQ = 1'b0; R1_REQ = 1'b0;
        cyc(); cyc();

        // Single source with held REQ.
        R0 = 16'h1234; R0_REQ = 1'b1;
        cyc();
        check("single_data", 32'(TO_BUS), 32'h1234);
        check("single_sel", 32'(SEL_BUS), 32'h0);
        check("single_valid", 32'(BUS_VALID), 32'h1);
        check("single_ack", 32'(R0_ACK), 32'h1);
        R0 = 16'h1235;
        cyc();
        check("single_ack_pulse", 32'(R0_ACK), 32'h0);
        cyc();
        check("single_next", 32'(TO_BUS), 32'h1235);
        R0_REQ = 1'b0;
        cyc(); cyc();

        // Backpressure with R1 pending.
        BUS_READY = 1'b0; R0 = 16'h0F0F; R0_REQ = 1'b1;
        cyc();
        R0_REQ = 1'b0; R1 = 16'h7777; R1_REQ = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            check("bp_hold", 32'({BUS_VALID, SEL_BUS, TO_BUS}), 32'h2_0F0F);
            check("bp_no_ack", 32'(R1_ACK), 32'h0);
        end
        BUS_READY = 1'b1;
        cyc();
        check("bp_release", 32'({SEL_BUS, TO_BUS}), 32'h1_7777);
        check("bp_r1_ack", 32'(R1_ACK), 32'h1);
        R1_REQ = 1'b0;

        // Drain.
        cyc();
        check("drain_valid", 32'(BUS_VALID), 32'h0);
        check("drain_hold", 32'(TO_BUS), 32'h7777);

        // Stale REQ: R1 drops REQ in its ACK cycle, exactly one word results.
        R1 = 16'h3C3C; R1_REQ = 1'b1;
        cyc();
        R1_REQ = 1'b0; R1 = 16'hDEAD;
        cyc(); cyc(); cyc();
        check("stale_hold", 32'({SEL_BUS, TO_BUS}), 32'h1_3C3C);

        // Asynchronous reset while FULL.
        BUS_READY = 1'b0; R0 = 16'hBEEF; R0_REQ = 1'b1;
        cyc();
        R0_REQ = 1'b0;
        cyc();
        check("pre_rst_full", 32'({BUS_VALID, TO_BUS}), 32'h1_BEEF);
        #2 RST_N = 1'b0;
        model_reset();
        #1;
        check("async_rst_to_bus", 32'(TO_BUS), 32'h0);
        check("async_rst_sel", 32'(SEL_BUS), 32'h0);
        check("async_rst_valid", 32'(BUS_VALID), 32'h0);
        check("async_rst_acks", 32'({R1_ACK, R0_ACK}), 32'h0);
        @(negedge CLK);
        #2 RST_N = 1'b1;

        // Random traffic; sources react to ACK as real producers would.
        for (int n = 0; n < 800; n++) begin
            cyc();
            if (R0_ACK) begin
                if ($urandom_range(0, 3) != 0) R0 = 16'($urandom); else R0_REQ = 1'b0;
            end else if (!R0_REQ && $urandom_range(0, 2) == 0) begin
                R0_REQ = 1'b1; R0 = 16'($urandom);
            end
            if (R1_ACK) begin
                if ($urandom_range(0, 3) != 0) R1 = 16'($urandom); else R1_REQ = 1'b0;
            end else if (!R1_REQ && $urandom_range(0, 2) == 0) begin
                R1_REQ = 1'b1; R1 = 16'($urandom);
            end
            BUS_READY = ($urandom_range(0, 9) < 7);
        end

        R0_REQ = 1'b0; R1_REQ = 1'b0; BUS_READY = 1'b1;
        for (int n = 0; n < 4; n++) cyc();
        check("final_queue_empty", 32'(exp_q.size()), 32'h0);
        check("final_idle", 32'(BUS_VALID), 32'h0);
        @(negedge CLK);
        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mux_bus16b_sel1b_arb.md
Name: mux_bus16b_sel1b_arb

Overview:
- Return-path counterpart of the 16-bit bus demux. Two register-side sources (R0, R1) compete to drive the shared 16-bit bus.
- Round-robin arbitration picks one source. Its word is captured into an output holding register and presented on TO_BUS with a valid/ready handshake.
- SEL_BUS reports which source owns the bus, using the same encoding the demux consumes: 0 = R0, 1 = R1.

Parameters:
- WIDTH, 16, data width of R0/R1/TO_BUS.

Ports:
- CLK  input  1  system clock, all state updates on rising edge
- RST_N  input  1  asynchronous active-low reset
- R0  input  WIDTH  source 0 data; stable while R0_REQ high and R0_ACK low
- R0_REQ  input  1  source 0 has a word pending
- R0_ACK  output  1  one-cycle pulse: source 0 word captured
- R1  input  WIDTH  source 1 data; same rule as R0
- R1_REQ  input  1  source 1 has a word pending
- R1_ACK  output  1  one-cycle pulse: source 1 word captured
- TO_BUS  output  WIDTH  registered bus data
- SEL_BUS  output  1  registered owner of TO_BUS (0 = R0, 1 = R1)
- BUS_VALID  output  1  TO_BUS/SEL_BUS hold a word
- BUS_READY  input  1  bus consumer accepts the word when BUS_VALID and BUS_READY are both high at an edge

Behaviour:
- Clock and reset: one clock, CLK. Reset is asynchronous and active-low on RST_N.
- Reset values: TO_BUS=0, SEL_BUS=0, BUS_VALID=0, R0_ACK=0, R1_ACK=0, state=IDLE, LAST_SEL=1, so R0 wins the first tie.
- States:
  - IDLE: BUS_VALID=0.
  - FULL: BUS_VALID=1.
- Eligibility at an edge: Rx_REQ=1 and Rx_ACK=0 in the current cycle. A source being acknowledged this cycle is masked because its REQ is stale.
- Capture event: taken at an edge when
  - state is IDLE, or
  - state is FULL and BUS_READY=1 (the word leaves the same edge),
  - and at least one source is eligible.
- On a capture event:
  - Winner data goes to TO_BUS and winner index goes to SEL_BUS and LAST_SEL.
  - State becomes FULL.
  - Winner's ACK is high for exactly the following cycle.
- Winner selection:
  - Only one source eligible: that source wins.
  - Both eligible: the source != LAST_SEL wins (round-robin).
- FULL with BUS_READY=1 and no eligible source: state becomes IDLE and BUS_VALID goes to 0. TO_BUS and SEL_BUS keep their last values.
- FULL with BUS_READY=0: all outputs hold and no ACK is issued. Requests wait indefinitely; there is no timeout.
- Latency and throughput:
  - Latency from REQ sampled to BUS_VALID: 1 edge.
  - Steady state with BUS_READY=1: one word per cycle on the bus.
  - A single source alone gets at most one word per 2 cycles because of the ACK mask.
- Source protocol:
  - Keeping REQ high in the cycle after ACK means a new word is presented from that cycle on.
  - Dropping REQ means nothing is pending.
- Reset asserted mid-transfer: the in-flight word is discarded and all outputs return to reset values immediately, with no clock needed.
- Only one of R0_ACK/R1_ACK can be high in any cycle.

Optional Feature:
- MUX_FIXED_PRIO_EN defined: ties always go to R0 (fixed priority) and LAST_SEL is unused. Source 1 can starve; this is accepted for debug/bring-up.
- Not defined: round-robin as specified above.

Decomposition:
- Shared package holds:
  - state enum {IDLE, FULL}
  - SEL_R0=1'b0 and SEL_R1=1'b1 constants, reused by the demux
  - BUS_W_DEFAULT=16
- Natural sub-module: arb_rr2. Combinational 2-way arbiter taking eligible[1:0] and last_sel, returning grant_valid and grant_sel. It honours MUX_FIXED_PRIO_EN internally.
- Datapath register and FSM stay in the top module.

Test Plan:
- Reset: drive RST_N=0 mid-FULL with TO_BUS=16'hBEEF → TO_BUS=0, SEL_BUS=0, BUS_VALID=0, ACKs=0 asynchronously, before the next CLK edge.
- Single source: R0=16'h1234, R0_REQ=1, BUS_READY=1 → next cycle TO_BUS=16'h1234, SEL_BUS=0, BUS_VALID=1, R0_ACK=1 for exactly 1 cycle. Holding REQ with new data 16'h1235 → captured 2 cycles later.
- Tie / round-robin: R0=16'hAAAA and R1=16'h5555 both requesting continuously, BUS_READY=1 → bus sequence AAAA(SEL 0), 5555(SEL 1), AAAA, 5555 on consecutive cycles. With MUX_FIXED_PRIO_EN: the first two words are AAAA then 5555 (R0 masked by its ACK), then AAAA again.
- Backpressure: BUS_READY=0 for 5 cycles with R1 pending → TO_BUS/SEL_BUS/BUS_VALID stable, R1_ACK stays 0. BUS_READY=1 → R1 word captured the same edge, R1_ACK the following cycle.
- Drain: after the last word, both REQ=0 and BUS_READY=1 → BUS_VALID drops to 0 one edge later and TO_BUS keeps its last value.
- Stale-REQ mask: R1 pulses REQ for exactly the capture cycle and drops it in the ACK cycle → exactly one word from R1, never duplicated.
